// File: rtl/fsk_pkg.sv
// fsk_pkg: shared types, widths and constants for the FSK symbol demodulator.
package fsk_pkg;
    typedef enum logic {IDLE, COUNT} state_t;
    localparam int STAT_W = 16;
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/fsk_symbol_demod_edge.sv
// fsk_edge_detect: synchronises the raw FSK input and emits a one-cycle rising-edge pulse.
module fsk_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic pulse
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    always_ff @(posedge clock) begin
        if (reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= SYNC_STAGES'({sync, raw});
            prev <= sync[SYNC_STAGES-1];
        end
    end
    always_comb pulse = ~prev & sync[SYNC_STAGES-1];
endmodule

// File: rtl/fsk_symbol_demod.sv
// fsk_symbol_demod: counts input edges per fixed window and decides mark/space with an erasure flag.
// Optional saturating symbol/erasure totals are enabled by defining FSK_DEMOD_STATS_EN.
module fsk_symbol_demod
    import fsk_pkg::*;
#(
    parameter int SYM_CYCLES  = 32,
    parameter int THRESH      = 8,
    parameter int MARGIN      = 2,
    parameter int SYNC_STAGES = 2,
    localparam int CNT_W      = cnt_width(SYM_CYCLES)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_input,
    input  logic             io_enable,
    output logic             io_sym_valid,
    output logic             io_sym_bit,
    output logic             io_sym_erasure,
    output logic [CNT_W-1:0] io_edge_count,
    output logic             io_busy
`ifdef FSK_DEMOD_STATS_EN
    ,
    output logic [STAT_W-1:0] io_sym_total,
    output logic [STAT_W-1:0] io_erasure_total
`endif
);
    localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(SYM_CYCLES - 1);
    localparam logic [CNT_W-1:0] TH       = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] LO       = CNT_W'(THRESH - MARGIN);
    localparam logic [CNT_W-1:0] HI       = CNT_W'(THRESH + MARGIN - 1);

    state_t           state, state_next;
    logic             edge_pulse, run, last, bit_d, erasure_d;
    logic [CNT_W-1:0] cyc_cnt, edge_cnt, edge_sum;

    fsk_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
        .clock (clock),
        .reset (reset),
        .raw   (io_input),
        .pulse (edge_pulse)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb state_next = io_enable ? COUNT : IDLE;

    always_comb io_busy = (state == COUNT);

    // edge_sum includes an edge landing in the current cycle, so the last cycle of a window counts
    always_comb begin
        run       = (state == COUNT) && io_enable;
        last      = run && (cyc_cnt == SYM_LAST);
        edge_sum  = (edge_pulse && edge_cnt != '1) ? edge_cnt + 1'b1 : edge_cnt;
        bit_d     = edge_sum >= TH;
        erasure_d = (MARGIN != 0) && (edge_sum >= LO) && (edge_sum <= HI);
    end

    always_ff @(posedge clock) begin
        if (reset || !run || last) begin
            cyc_cnt  <= '0;
            edge_cnt <= '0;
        end else begin
            cyc_cnt  <= cyc_cnt + 1'b1;
            edge_cnt <= edge_sum;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            io_sym_valid   <= 1'b0;
            io_sym_bit     <= 1'b0;
            io_sym_erasure <= 1'b0;
            io_edge_count  <= '0;
        end else begin
            io_sym_valid <= last;
            if (last) begin
                io_sym_bit     <= bit_d;
                io_sym_erasure <= erasure_d;
                io_edge_count  <= edge_sum;
            end
        end
    end

`ifdef FSK_DEMOD_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            io_sym_total     <= '0;
            io_erasure_total <= '0;
        end else if (last) begin
            io_sym_total     <= io_sym_total + STAT_W'(io_sym_total != '1);
            io_erasure_total <= io_erasure_total + STAT_W'(erasure_d && io_erasure_total != '1);
        end
    end
`endif
endmodule
